bsg_arb_rr_locked: RTL and testbench

BSG_ARB_RR_LOCKED -- requirements
Module: bsg_arb_rr_locked

---
 rtl/bsg_arb_pkg.sv | 13 +
 rtl/bsg_scan.sv | 36 +++
 rtl/bsg_arb_rr_locked.sv | 133 +++++++++++++
 tb/tb_bsg_arb_rr_locked.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_arb_pkg.sv
// Shared definitions for the locked round-robin arbiter: FSM encoding and
// the legal requestor-count range.
package bsg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_MIN_WIDTH = 2;
    localparam int ARB_MAX_WIDTH = 32;

endpackage : bsg_arb_pkg

// File: rtl/bsg_scan.sv
// Parallel prefix scan (OR or AND), either low-to-high or high-to-low.
// Each output bit is a direct reduction, so no bit depends on another output.
module bsg_scan #(
    parameter int width_p    = -1,
    parameter bit or_p       = 1'b0,
    parameter bit lo_to_hi_p = 1'b0
) (
    input  logic [width_p-1:0] i,
    output logic [width_p-1:0] o
);

    logic [width_p-1:0] in_ord;
    logic [width_p-1:0] scan_ord;

    // Reorder so the scan always runs from index 0 upward, then undo it.
    generate
        for (genvar gi = 0; gi < width_p; gi++) begin : g_order
            if (lo_to_hi_p) begin : g_lo
                assign in_ord[gi] = i[gi];
                assign o[gi]      = scan_ord[gi];
            end else begin : g_hi
                assign in_ord[gi] = i[width_p-1-gi];
                assign o[gi]      = scan_ord[width_p-1-gi];
            end
        end

        for (genvar gi = 0; gi < width_p; gi++) begin : g_scan
            if (or_p) begin : g_or
                assign scan_ord[gi] = |in_ord[gi:0];
            end else begin : g_and
                assign scan_ord[gi] = &in_ord[gi:0];
            end
        end
    endgenerate

endmodule : bsg_scan

// File: rtl/bsg_arb_rr_locked.sv
// Round-robin arbiter whose grant is registered and held until the consumer
// accepts it with yumi_i; back-to-back acceptance sustains one grant per cycle.
module bsg_arb_rr_locked
    import bsg_arb_pkg::*;
#(
    parameter int width_p    = -1,
    parameter int lg_width_p = $clog2(width_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [width_p-1:0]    reqs_i,
    output logic                  v_o,
    output logic [width_p-1:0]    grants_o,
    output logic [lg_width_p-1:0] tag_o,
    input  logic                  yumi_i
);

    arb_state_e              state_reg, state_next;
    logic [lg_width_p-1:0]   ptr_reg, ptr_next;
    logic [width_p-1:0]      grants_reg, grants_next;
    logic [lg_width_p-1:0]   tag_reg, tag_next;

    logic [lg_width_p-1:0]   ptr_sel;
    logic [width_p-1:0]      mask;
    logic [width_p-1:0]      masked;
    logic [width_p-1:0]      masked_scan;
    logic [width_p-1:0]      reqs_scan;
    logic [width_p-1:0]      masked_oh;
    logic [width_p-1:0]      reqs_oh;
    logic [width_p-1:0]      winner_oh;
    logic [lg_width_p-1:0]   winner_tag;
    logic                    accept;

    assign accept = (state_reg == GRANT) && yumi_i;

    // On an accepting cycle the pointer is about to load tag_reg, so
    // arbitrate against that value rather than the stale register.
    assign ptr_sel = accept ? tag_reg : ptr_reg;

    generate
        for (genvar gi = 0; gi < width_p; gi++) begin : g_mask
            assign mask[gi] = (gi > int'(ptr_sel));
        end
    endgenerate

    assign masked = reqs_i & mask;

    bsg_scan #(
        .width_p    (width_p),
        .or_p       (1'b1),
        .lo_to_hi_p (1'b1)
    ) u_scan_masked (
        .i (masked),
        .o (masked_scan)
    );

    bsg_scan #(
        .width_p    (width_p),
        .or_p       (1'b1),
        .lo_to_hi_p (1'b1)
    ) u_scan_reqs (
        .i (reqs_i),
        .o (reqs_scan)
    );

    // First set bit is where the prefix OR turns on.
    assign masked_oh = masked_scan & ~(masked_scan << 1);
    assign reqs_oh   = reqs_scan   & ~(reqs_scan   << 1);
    assign winner_oh = (|masked) ? masked_oh : reqs_oh;

    always_comb begin
        winner_tag = '0;
        for (int k = 0; k < width_p; k++) begin
            if (winner_oh[k]) begin
                winner_tag = winner_tag | lg_width_p'(k);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        grants_next = grants_reg;
        tag_next    = tag_reg;
        case (state_reg)
            IDLE: begin
                if (|reqs_i) begin
                    state_next  = GRANT;
                    grants_next = winner_oh;
                    tag_next    = winner_tag;
                end
            end
            GRANT: begin
                if (yumi_i) begin
                    ptr_next = tag_reg;
                    if (|reqs_i) begin
                        grants_next = winner_oh;
                        tag_next    = winner_tag;
                    end else begin
                        state_next  = IDLE;
                        grants_next = '0;
                        tag_next    = '0;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                grants_next = '0;
                tag_next    = '0;
            end
        endcase
    end

    // Pointer resets to the top index so the first grant wraps to index 0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg  <= IDLE;
            ptr_reg    <= lg_width_p'(width_p - 1);
            grants_reg <= '0;
            tag_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            grants_reg <= grants_next;
            tag_reg    <= tag_next;
        end
    end

    assign v_o      = (state_reg == GRANT);
    assign grants_o = grants_reg;
    assign tag_o    = tag_reg;

endmodule : bsg_arb_rr_locked

// File: tb/tb_bsg_arb_rr_locked.sv
// Bench for the locked round-robin arbiter at width 4: directed vector table,
// hand-written reset/rotation sequences, and random traffic against a model.
module tb_bsg_arb_rr_locked;

    localparam int W  = 4;
    localparam int LW = 2;

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  reqs;
    logic          yumi;
    logic          v_o;
    logic [W-1:0]  grants_o;
    logic [LW-1:0] tag_o;

    int checks = 0;
    int errors = 0;

    // Reference model: valid flag, granted index, last-accepted index.
    bit m_v;
    int m_idx;
    int m_ptr;

    typedef struct {
        logic [W-1:0]  reqs;
        logic          yumi;
        logic          v;
        logic [W-1:0]  grants;
        logic [LW-1:0] tag;
    } vec_t;

    vec_t tbl[16];

    bsg_arb_rr_locked #(
        .width_p    (W),
        .lg_width_p (LW)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .reqs_i    (reqs),
        .v_o       (v_o),
        .grants_o  (grants_o),
        .tag_o     (tag_o),
        .yumi_i    (yumi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_v   = 1'b0;
        m_idx = 0;
        m_ptr = W - 1;
    endtask

    // Search cyclically upward from the index after p.
    function automatic int pick(input logic [W-1:0] r, input int p);
        for (int k = 1; k <= W; k++) begin
            if (r[(p + k) % W]) return (p + k) % W;
        end
        return 0;
    endfunction

    task automatic model_step(input logic [W-1:0] r, input logic y);
        if (!m_v) begin
            if (r != 0) begin
                m_v   = 1'b1;
                m_idx = pick(r, m_ptr);
            end
        end else if (y) begin
            m_ptr = m_idx;
            if (r != 0) m_idx = pick(r, m_ptr);
            else        m_v = 1'b0;
        end
    endtask

    // Called at a falling edge: drive, advance the model, wait for next falling edge.
    task automatic step(input logic [W-1:0] r, input logic y);
        reqs = r;
        yumi = y;
        if (y && !m_v)
            $display("note: yumi_i asserted while idle at %0t -- flagged, must be ignored", $time);
        model_step(r, y);
        @(negedge clk);
    endtask

    task automatic check_model(input string name);
        check({name, "_v"},      32'(v_o),      32'(m_v));
        check({name, "_grants"}, 32'(grants_o), m_v ? (32'd1 << m_idx) : 32'd0);
        check({name, "_tag"},    32'(tag_o),    m_v ? 32'(m_idx) : 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        reqs    = '0;
        yumi    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    logic [W-1:0] rot_exp[4];

    initial begin
        tbl[0]  = '{4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1};
        tbl[1]  = '{4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1};
        tbl[6]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2};
        tbl[7]  = '{4'b0001, 1'b0, 1'b1, 4'b0100, 2'd2};
        tbl[8]  = '{4'b0001, 1'b0, 1'b1, 4'b0100, 2'd2};
        tbl[9]  = '{4'b0000, 1'b0, 1'b1, 4'b0100, 2'd2};
        tbl[10] = '{4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3};
        tbl[11] = '{4'b1001, 1'b1, 1'b1, 4'b0001, 2'd0};
        tbl[12] = '{4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3};
        tbl[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0};
        tbl[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0};
        tbl[15] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2};

        reset_n = 1'b0;
        reqs    = '0;
        yumi    = 1'b0;
        model_reset();
        #2;
        check("reset_v",      32'(v_o),      32'd0);
        check("reset_grants", 32'(grants_o), 32'd0);
        check("reset_tag",    32'(tag_o),    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vector table.
        for (int n = 0; n < 16; n++) begin
            step(tbl[n].reqs, tbl[n].yumi);
            check($sformatf("tbl%0d_v", n),      32'(v_o),      32'(tbl[n].v));
            check($sformatf("tbl%0d_grants", n), 32'(grants_o), 32'(tbl[n].grants));
            check($sformatf("tbl%0d_tag", n),    32'(tag_o),    32'(tbl[n].tag));
        end

        // Asynchronous reset in the middle of a grant.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_v",      32'(v_o),      32'd0);
        check("async_rst_grants", 32'(grants_o), 32'd0);
        check("async_rst_tag",    32'(tag_o),    32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(4'b1000, 1'b0);
        check("post_rst_grants", 32'(grants_o), 32'b1000);
        check("post_rst_tag",    32'(tag_o),    32'd3);
        check_model("post_rst");

        // Strict rotation with all requests held and no bubbles.
        do_reset();
        step(4'b1111, 1'b0);
        check("rot_first", 32'(grants_o), 32'b0001);
        rot_exp[0] = 4'b0010;
        rot_exp[1] = 4'b0100;
        rot_exp[2] = 4'b1000;
        rot_exp[3] = 4'b0001;
        for (int n = 0; n < 4; n++) begin
            step(4'b1111, 1'b1);
            check($sformatf("rot%0d_v", n),      32'(v_o),      32'd1);
            check($sformatf("rot%0d_grants", n), 32'(grants_o), 32'(rot_exp[n]));
        end

        // Random traffic; yumi only while the model says a grant is valid.
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] r;
            logic         y;
            r = W'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = '0;
            y = m_v ? 1'($urandom_range(0, 1)) : 1'b0;
            step(r, y);
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bsg_arb_rr_locked
